// File: rtl/pwm_pkg.sv
// Shared definitions for the count-driven PWM block: FSM state encoding and default widths.
package pwm_pkg;

    localparam int PWM_WIDTH = 4;
    localparam int PWM_CYC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/duty_slot.sv
// One-entry duty holding register: valid/ready load, emptied by an apply strobe at a period start.
module duty_slot
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             ready,
    input  logic             apply,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_reg;
    logic [WIDTH-1:0] data_reg;

    // Apply and accept are mutually exclusive: accept needs the slot empty, apply only acts on a full slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (apply && full_reg) begin
            full_reg <= 1'b0;
        end else if (in_valid && !full_reg) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end
    end

    assign ready = !full_reg;
    assign full  = full_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pwm_from_count.sv
// PWM generator slaved to an upstream free-running counter; duty changes land only on period starts,
// and a break in the +1 count sequence is flagged and forces a resync.
module pwm_from_count
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int CYC_W = PWM_CYC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] duty_data,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             wrap,
    output logic [CYC_W-1:0] period_cnt,
    output logic             seq_err
);

    pwm_state_t       state_reg, state_next;
    logic [WIDTH-1:0] prev_count_reg;
    logic [WIDTH-1:0] active_duty_reg;
    logic             pwm_reg, pwm_next;
    logic             wrap_reg;
    logic [CYC_W-1:0] period_cnt_reg;
    logic             seq_err_reg;

    logic             period_start;
    logic             seq_fault;
    logic             drive_cmp;
    logic             slot_full;
    logic [WIDTH-1:0] slot_data;
    logic [WIDTH-1:0] duty_eff;
    logic [WIDTH-1:0] count_expect;

    duty_slot #(.WIDTH(WIDTH)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (duty_data),
        .in_valid (duty_valid),
        .ready    (duty_ready),
        .apply    (period_start),
        .full     (slot_full),
        .data     (slot_data)
    );

    assign count_expect = prev_count_reg + WIDTH'(1);

    always_comb begin
        state_next   = state_reg;
        period_start = 1'b0;
        seq_fault    = 1'b0;
        drive_cmp    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) state_next = SYNC;
            end
            SYNC: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    // Alignment cycle counts as a period start; prev_count is not trusted yet.
                    state_next   = RUN;
                    period_start = 1'b1;
                    drive_cmp    = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count != count_expect) begin
                    seq_fault  = 1'b1;
                    state_next = SYNC;
                end else begin
                    drive_cmp    = 1'b1;
                    period_start = (count == '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The freshly applied duty governs the very first cycle of its period.
    assign duty_eff = (period_start && slot_full) ? slot_data : active_duty_reg;
    assign pwm_next = drive_cmp && (count < duty_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            prev_count_reg  <= '0;
            active_duty_reg <= '0;
            pwm_reg         <= 1'b0;
            wrap_reg        <= 1'b0;
            period_cnt_reg  <= '0;
            seq_err_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_count_reg <= count;
            pwm_reg        <= pwm_next;
            wrap_reg       <= period_start;
            if (period_start) period_cnt_reg <= period_cnt_reg + CYC_W'(1);
            if (period_start && slot_full) active_duty_reg <= slot_data;
            if (seq_fault) seq_err_reg <= 1'b1;
        end
    end

    assign pwm_out    = pwm_reg;
    assign wrap       = wrap_reg;
    assign period_cnt = period_cnt_reg;
    assign seq_err    = seq_err_reg;

endmodule

// File: tb/tb_pwm_from_count.sv
// Scenario bench for pwm_from_count: directed period-level checks plus randomized cycles against a behavioural model.
module tb_pwm_from_count;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] count = 4'd0;
    logic [3:0] duty_data = 4'd0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_out;
    logic       wrap;
    logic [7:0] period_cnt;
    logic       seq_err;

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    pwm_from_count #(.WIDTH(4), .CYC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count      (count),
        .duty_data  (duty_data),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .wrap       (wrap),
        .period_cnt (period_cnt),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 waiting for count 0, 2 running.
    int m_mode = 0, m_prev = 0, m_active = 0, m_pend = 0, m_pcnt = 0;
    bit m_full = 0, m_pwm = 0, m_wrap = 0, m_err = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int  c, eff, nmode;
        bit  start, drive;
        if (!rst_n) begin
            m_mode <= 0; m_prev <= 0; m_active <= 0; m_pend <= 0; m_pcnt <= 0;
            m_full <= 0; m_pwm <= 0; m_wrap <= 0; m_err <= 0;
        end else begin
            c = int'(count);
            start = 0; drive = 0; nmode = m_mode;
            if (m_mode == 1 && en && c == 0) begin
                nmode = 2; start = 1; drive = 1;
            end else if (m_mode == 2 && en) begin
                if (c != (m_prev + 1) % 16) begin
                    nmode = 1; m_err <= 1;
                end else begin
                    drive = 1; start = (c == 0);
                end
            end
            if (!en) nmode = 0;
            else if (m_mode == 0) nmode = 1;
            eff = (start && m_full) ? m_pend : m_active;
            m_pwm  <= drive && (c < eff);
            m_wrap <= start;
            if (start) m_pcnt <= (m_pcnt + 1) % 256;
            if (start && m_full) begin
                m_active <= m_pend; m_full <= 0;
            end else if (duty_valid && !m_full) begin
                m_full <= 1; m_pend <= int'(duty_data);
            end
            m_prev <= c;
            m_mode <= nmode;
        end
    end

    function automatic logic [15:0] mask(input int d);
        logic [16:0] m;
        m = (17'd1 << d) - 17'd1;
        return m[15:0];
    endfunction

    // Drive the next counter value and move to the following falling edge.
    task automatic step();
        count = 4'(cnt);
        cnt = (cnt + 1) % 16;
        @(negedge clk);
    endtask

    task automatic advance_to(input int v);
        for (int i = 0; i < 16 && cnt != v; i++) step();
    endtask

    task automatic load_duty(input int d);
        int waited = 0;
        while (!duty_ready && waited < 40) begin
            step();
            waited++;
        end
        checks++;
        if (!duty_ready) begin
            errors++;
            $display("FAIL load_ready_timeout: duty_ready=%0b required 1 within 40 cycles", duty_ready);
        end
        duty_valid = 1'b1;
        duty_data = 4'(d);
        step();
        duty_valid = 1'b0;
    endtask

    // One full period starting from a count of 0; optionally offers a duty at offset load_at.
    task automatic run_period(input int load_at, input int load_val, output logic [15:0] pat,
                              output logic wrap0, output int pcnt0, output logic ready0,
                              output logic ready_low, output int extra_wraps);
        advance_to(0);
        pat = '0; ready_low = 1'b1; extra_wraps = 0; wrap0 = 1'b0; pcnt0 = 0; ready0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == load_at) begin
                duty_valid = 1'b1;
                duty_data = 4'(load_val);
            end
            step();
            duty_valid = 1'b0;
            pat[i] = pwm_out;
            if (i == 0) begin
                wrap0 = wrap; pcnt0 = int'(period_cnt); ready0 = duty_ready;
            end else begin
                extra_wraps += int'(wrap);
            end
            if (load_at >= 0 && i >= load_at && duty_ready) ready_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks += 5;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_period_cnt: got %0d want 0", period_cnt); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
        if (duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", duty_ready); end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic_pwm();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw;
        load_duty(4);
        en = 1'b1;
        step();
        advance_to(0);
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL basic_prewrap: wrap=%b want 0 before count 0", wrap); end
        for (int p = 1; p <= 3; p++) begin
            run_period(-1, 0, pat, w0, p0, r0, rl, xw);
            checks += 4;
            if (w0 !== 1'b1) begin errors++; $display("FAIL basic_wrap p%0d: got %b want 1", p, w0); end
            if (p0 != p) begin errors++; $display("FAIL basic_period_cnt: got %0d want %0d", p0, p); end
            if (pat !== mask(4)) begin errors++; $display("FAIL basic_pattern p%0d: got %h want %h", p, pat, mask(4)); end
            if (xw != 0) begin errors++; $display("FAIL basic_extra_wrap p%0d: got %0d want 0", p, xw); end
            $display("basic period %0d: pattern=%h period_cnt=%0d", p, pat, p0);
        end
    endtask

    task automatic test_mid_period_change();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw;
        run_period(7, 10, pat, w0, p0, r0, rl, xw);
        checks += 2;
        if (pat !== mask(4)) begin errors++; $display("FAIL mid_old_period: got %h want %h", pat, mask(4)); end
        if (rl !== 1'b1) begin errors++; $display("FAIL mid_ready_low: ready rose before wrap (flag %b want 1)", rl); end
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks += 3;
        if (pat !== mask(10)) begin errors++; $display("FAIL mid_new_period: got %h want %h", pat, mask(10)); end
        if (w0 !== 1'b1) begin errors++; $display("FAIL mid_wrap: got %b want 1", w0); end
        if (r0 !== 1'b1) begin errors++; $display("FAIL mid_ready_after_wrap: got %b want 1", r0); end
        $display("mid-period change: new pattern=%h", pat);
    endtask

    task automatic test_boundaries();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw, prev_p;
        bit seen;
        load_duty(0);
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks++;
        if (pat !== 16'h0000) begin errors++; $display("FAIL duty0_pattern: got %h want 0000", pat); end
        load_duty(15);
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks++;
        if (pat !== 16'h7fff) begin errors++; $display("FAIL duty15_pattern: got %h want 7fff", pat); end
        $display("boundaries: duty0 and duty15 periods done");
        prev_p = p0; seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            run_period(-1, 0, pat, w0, p0, r0, rl, xw);
            checks++;
            if (p0 != (prev_p + 1) % 256) begin
                errors++; $display("FAIL period_cnt_step: got %0d want %0d", p0, (prev_p + 1) % 256);
            end
            if (prev_p == 255) begin
                seen = 1;
                $display("period_cnt wrap: 255 -> %0d", p0);
            end
            prev_p = p0;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL period_cnt_wrap: wrap past 255 seen=%0b want 1", seen); end
    endtask

    task automatic test_seq_err();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw; int stray;
        advance_to(5);
        step();
        cnt = 9;
        step();
        checks += 3;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set: got %b want 1", seq_err); end
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL seq_err_pwm: got %b want 0", pwm_out); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL seq_err_wrap: got %b want 0", wrap); end
        stray = 0;
        while (cnt != 0) begin
            step();
            stray += int'(pwm_out) + int'(wrap);
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL seq_err_quiet: pwm/wrap highs %0d want 0", stray); end
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks += 3;
        if (w0 !== 1'b1) begin errors++; $display("FAIL seq_resync_wrap: got %b want 1", w0); end
        if (pat !== 16'h7fff) begin errors++; $display("FAIL seq_resync_pattern: got %h want 7fff", pat); end
        if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky: got %b want 1", seq_err); end
        $display("sequence error: flagged and resynced");
    endtask

    task automatic test_enable();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw, stray, pc;
        advance_to(3);
        pc = int'(period_cnt);
        en = 1'b0;
        step();
        checks += 2;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL en_off_pwm: got %b want 0", pwm_out); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL en_off_wrap: got %b want 0", wrap); end
        stray = 0;
        while (cnt != 6) begin step(); stray += int'(pwm_out); end
        en = 1'b1;
        while (cnt != 0) begin step(); stray += int'(pwm_out) + int'(wrap); end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL en_resume_early: pwm/wrap highs %0d want 0", stray); end
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks += 3;
        if (w0 !== 1'b1) begin errors++; $display("FAIL en_resume_wrap: got %b want 1", w0); end
        if (p0 != (pc + 1) % 256) begin errors++; $display("FAIL en_period_kept: got %0d want %0d", p0, (pc + 1) % 256); end
        if (pat !== 16'h7fff) begin errors++; $display("FAIL en_duty_kept: got %h want 7fff", pat); end
        $display("enable toggle: resumed at count 0");
    endtask

    task automatic test_reset_mid();
        logic [15:0] pat; logic w0, r0, rl; int p0, xw;
        load_duty(7);
        advance_to(8);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b want 0", pwm_out); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %b want 0", wrap); end
        if (period_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_period_cnt: got %0d want 0", period_cnt); end
        if (seq_err !== 1'b0) begin errors++; $display("FAIL async_reset_seq_err: got %b want 0", seq_err); end
        if (duty_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b want 1", duty_ready); end
        step();
        rst_n = 1'b1;
        step();
        run_period(-1, 0, pat, w0, p0, r0, rl, xw);
        checks += 3;
        if (pat !== 16'h0000) begin errors++; $display("FAIL reset_pending_lost: got %h want 0000", pat); end
        if (w0 !== 1'b1) begin errors++; $display("FAIL reset_resume_wrap: got %b want 1", w0); end
        if (p0 != 1) begin errors++; $display("FAIL reset_resume_period: got %0d want 1", p0); end
        $display("mid-period reset: outputs cleared, pending duty dropped");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 99) >= 3);
            if (duty_ready && $urandom_range(0, 9) == 0) begin
                duty_valid = 1'b1;
                duty_data = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) cnt = int'($urandom_range(0, 15));
            step();
            duty_valid = 1'b0;
            checks += 5;
            if (pwm_out !== m_pwm) begin errors++; $display("FAIL rand_pwm cyc%0d: got %b want %b", i, pwm_out, m_pwm); end
            if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap cyc%0d: got %b want %b", i, wrap, m_wrap); end
            if (int'(period_cnt) != m_pcnt) begin errors++; $display("FAIL rand_period_cnt cyc%0d: got %0d want %0d", i, period_cnt, m_pcnt); end
            if (seq_err !== m_err) begin errors++; $display("FAIL rand_seq_err cyc%0d: got %b want %b", i, seq_err, m_err); end
            if (duty_ready !== !m_full) begin errors++; $display("FAIL rand_ready cyc%0d: got %b want %b", i, duty_ready, !m_full); end
        end
        $display("random: 3000 cycles compared against model");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_pwm();
        test_mid_period_change();
        test_boundaries();
        test_seq_err();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
